// File: rtl/gate_test_pkg.sv
// Shared types and reference truth tables for the gate truth-table sweeper.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit i is the expected output when the gate inputs equal i.
    localparam logic [3:0] TT_NAND2 = 4'b0111;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_truth_sweeper.sv
// Drives every input combination into a combinational gate, waits for it to
// settle, and checks the sampled output against an expected truth table.
module gate_truth_sweeper
    import gate_test_pkg::*;
#(
    parameter int              N_IN   = 2,
    parameter int              SETTLE = 1,
    parameter logic [2**N_IN-1:0] TRUTH = TT_NAND2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            gate_out,
    output logic [N_IN-1:0] gate_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_idx
);

    localparam logic [N_IN-1:0] LAST_IDX   = '1;
    localparam logic [N_IN:0]   ERR_MAX    = (N_IN+1)'(2**N_IN);
    localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

    state_t          state;
    logic [N_IN-1:0] idx;
    logic [3:0]      wait_cnt;
    logic            mismatch;

    function automatic logic [N_IN:0] sat_inc(input logic [N_IN:0] v);
        if (v == ERR_MAX)
            return v;
        return v + 1'b1;
    endfunction

    assign mismatch = (gate_out != TRUTH[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gate_in       <= '0;
            idx           <= '0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        gate_in   <= '0;
                        idx       <= '0;
                        wait_cnt  <= SETTLE_CNT;
                        err_count <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0)
                        state <= SAMPLE;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count <= sat_inc(err_count);
                        if (err_count == '0)
                            first_err_idx <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx      <= idx + 1'b1;
                        gate_in  <= idx + 1'b1;
                        wait_cnt <= SETTLE_CNT;
                        state    <= WAIT;
                    end
                end
                DONE: begin
                    // err_count already includes the final SAMPLE's result here.
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
